// File: rtl/conv_loop_sequencer.sv
// Convolution loop odometer (m, r, c, n, i, j) with per-pixel accumulator framing
// and a delayed output-buffer write strobe aligned to the MAC pipeline latency.
module conv_loop_sequencer #(
  parameter int K          = 5,
  parameter int OUT_SIZE   = 28,
  parameter int OUT_CH     = 6,
  parameter int IN_CH      = 1,
  parameter int N_STEP     = 4,
  parameter int PIPE_DEPTH = 9
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  output logic        busy,
  output logic        done,
  output logic [7:0]  m,
  output logic [7:0]  r,
  output logic [7:0]  c,
  output logic [7:0]  n,
  output logic [3:0]  i,
  output logic [3:0]  j,
  output logic        beat_valid,
  output logic        acc_clr,
  output logic        acc_last,
  output logic        out_wr,
  output logic [15:0] out_addr,
  output logic [7:0]  out_chan
);
  localparam int N_MAX = ((IN_CH - 1) / N_STEP) * N_STEP;
  localparam int CW    = $clog2(PIPE_DEPTH + 1);
  localparam logic [7:0]    M_MAX      = 8'(OUT_CH - 1);
  localparam logic [7:0]    RC_MAX     = 8'(OUT_SIZE - 1);
  localparam logic [7:0]    N_MAX_W    = 8'(N_MAX);
  localparam logic [7:0]    N_STEP_W   = 8'(N_STEP);
  localparam logic [3:0]    K_MAX      = 4'(K - 1);
  localparam logic [15:0]   OUT_SIZE_W = 16'(OUT_SIZE);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(PIPE_DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [7:0]      m_r, r_r, c_r, n_r, m_s, r_s, c_s, n_s;
  logic [3:0]      i_r, j_r, i_s, j_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            j_wrap_s, i_wrap_s, n_wrap_s, c_wrap_s, r_wrap_s, m_wrap_s;
  logic            carry_i_s, carry_n_s, carry_c_s, carry_r_s, carry_m_s;
  logic            beat_s, last_beat_s, acc_clr_s, acc_last_s;
  logic [15:0]     pix_addr_s;
  logic [PIPE_DEPTH-1:0] wr_pipe_r;
  logic [15:0]     addr_pipe_r [PIPE_DEPTH];
  logic [7:0]      chan_pipe_r [PIPE_DEPTH];

  // Wrap detection, carry chain and per-beat framing
  always_comb begin
    j_wrap_s    = (j_r == K_MAX);
    i_wrap_s    = (i_r == K_MAX);
    n_wrap_s    = (n_r == N_MAX_W);
    c_wrap_s    = (c_r == RC_MAX);
    r_wrap_s    = (r_r == RC_MAX);
    m_wrap_s    = (m_r == M_MAX);
    carry_i_s   = j_wrap_s;
    carry_n_s   = carry_i_s & i_wrap_s;
    carry_c_s   = carry_n_s & n_wrap_s;
    carry_r_s   = carry_c_s & c_wrap_s;
    carry_m_s   = carry_r_s & r_wrap_s;
    last_beat_s = carry_m_s & m_wrap_s;
    beat_s      = (state_r == RUN) & ~stall;
    acc_clr_s   = beat_s & (n_r == 8'd0) & (i_r == 4'd0) & (j_r == 4'd0);
    acc_last_s  = beat_s & carry_c_s;
    pix_addr_s  = ({8'd0, r_r} * OUT_SIZE_W) + {8'd0, c_r};
  end

  // Next-state and odometer advance; the final beat wraps every field back to 0
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    m_s = m_r; r_s = r_r; c_s = c_r; n_s = n_r; i_s = i_r; j_s = j_r;
    case (state_r)
      IDLE: begin
        m_s = 8'd0; r_s = 8'd0; c_s = 8'd0; n_s = 8'd0; i_s = 4'd0; j_s = 4'd0;
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (beat_s) begin
          j_s = j_wrap_s ? 4'd0 : j_r + 4'd1;
          i_s = carry_i_s ? (i_wrap_s ? 4'd0 : i_r + 4'd1) : i_r;
          n_s = carry_n_s ? (n_wrap_s ? 8'd0 : n_r + N_STEP_W) : n_r;
          c_s = carry_c_s ? (c_wrap_s ? 8'd0 : c_r + 8'd1) : c_r;
          r_s = carry_r_s ? (r_wrap_s ? 8'd0 : r_r + 8'd1) : r_r;
          m_s = carry_m_s ? (m_wrap_s ? 8'd0 : m_r + 8'd1) : m_r;
          if (last_beat_s) begin
            state_s = DRAIN;
            cnt_s   = '0;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (cnt_r == DRAIN_LAST) state_s = DONE;
        else                     cnt_s   = cnt_r + CNT_ONE;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        m_s = 8'd0; r_s = 8'd0; c_s = 8'd0; n_s = 8'd0; i_s = 4'd0; j_s = 4'd0;
      end
    endcase
  end

  // State, iterator and drain-counter registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      m_r <= 8'd0; r_r <= 8'd0; c_r <= 8'd0; n_r <= 8'd0; i_r <= 4'd0; j_r <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      m_r <= m_s; r_r <= r_s; c_r <= c_s; n_r <= n_s; i_r <= i_s; j_r <= j_s;
    end
  end

  // Write delay line; shifts every cycle so stall bubbles travel as empty slots
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_pipe_r <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        addr_pipe_r[k] <= 16'd0;
        chan_pipe_r[k] <= 8'd0;
      end
    end else begin
      wr_pipe_r[0]   <= acc_last_s;
      addr_pipe_r[0] <= pix_addr_s;
      chan_pipe_r[0] <= m_r;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        wr_pipe_r[k]   <= wr_pipe_r[k-1];
        addr_pipe_r[k] <= addr_pipe_r[k-1];
        chan_pipe_r[k] <= chan_pipe_r[k-1];
      end
    end
  end

  assign busy       = (state_r == RUN) | (state_r == DRAIN);
  assign done       = (state_r == DONE);
  assign m          = m_r;
  assign r          = r_r;
  assign c          = c_r;
  assign n          = n_r;
  assign i          = i_r;
  assign j          = j_r;
  assign beat_valid = beat_s;
  assign acc_clr    = acc_clr_s;
  assign acc_last   = acc_last_s;
  assign out_wr     = wr_pipe_r[PIPE_DEPTH-1];
  assign out_addr   = addr_pipe_r[PIPE_DEPTH-1];
  assign out_chan   = chan_pipe_r[PIPE_DEPTH-1];
endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Bench for conv_loop_sequencer: cycle-accurate model with a write scoreboard on a
// small layer, plus a second instance exercising multi-step input channels.
module tb_conv_loop_sequencer;
  localparam int K = 2, OS = 2, OC = 2, IC = 1, NS = 4, PD = 3;
  localparam int NMAX  = ((IC - 1) / NS) * NS;
  localparam int TOTAL = OC * OS * OS * ((IC + NS - 1) / NS) * K * K;

  logic clock = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
  logic busy, done, beat_valid, acc_clr, acc_last, out_wr;
  logic [7:0] m, r, c, n, out_chan;
  logic [3:0] i, j;
  logic [15:0] out_addr;

  logic start_b = 1'b0, stall_b = 1'b0;
  logic busy_b, done_b, beat_valid_b, acc_clr_b, acc_last_b, out_wr_b;
  logic [7:0] m_b, r_b, c_b, n_b, out_chan_b;
  logic [3:0] i_b, j_b;
  logic [15:0] out_addr_b;

  conv_loop_sequencer #(.K(K), .OUT_SIZE(OS), .OUT_CH(OC), .IN_CH(IC), .N_STEP(NS), .PIPE_DEPTH(PD)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .stall(stall), .busy(busy), .done(done),
    .m(m), .r(r), .c(c), .n(n), .i(i), .j(j), .beat_valid(beat_valid), .acc_clr(acc_clr),
    .acc_last(acc_last), .out_wr(out_wr), .out_addr(out_addr), .out_chan(out_chan));

  conv_loop_sequencer #(.K(1), .OUT_SIZE(2), .OUT_CH(1), .IN_CH(6), .N_STEP(4), .PIPE_DEPTH(2)) dut_b (
    .clock(clock), .rst_n(rst_n), .start(start_b), .stall(stall_b), .busy(busy_b), .done(done_b),
    .m(m_b), .r(r_b), .c(c_b), .n(n_b), .i(i_b), .j(j_b), .beat_valid(beat_valid_b),
    .acc_clr(acc_clr_b), .acc_last(acc_last_b), .out_wr(out_wr_b), .out_addr(out_addr_b),
    .out_chan(out_chan_b));

  always #5 clock = ~clock;

  int checks = 0, errors = 0;

  task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {int off; logic [15:0] addr; logic [7:0] chan;} wr_t;
  wr_t wr_q[$];
  bit active = 1'b0;
  int cyc = 0, t0 = 0, beats = 0, done_off = 0, last_off = 0, done_gap = 0;
  int em = 0, er = 0, ec = 0, en = 0, ei = 0, ej = 0;
  int n_bv = 0, n_clr = 0, n_last = 0, n_wr = 0, layers_done = 0, total_wr = 0;

  // Reference model: predicts every output each cycle and schedules writes PD cycles after the pixel's last beat
  always @(negedge clock) begin
    bit ebv, eclr, elast, ewr, edone;
    int off;
    wr_t w;
    cyc++;
    if (!rst_n) begin
      active = 1'b0; beats = 0; wr_q.delete();
      em = 0; er = 0; ec = 0; en = 0; ei = 0; ej = 0;
    end
    off   = cyc - t0;
    ebv   = active && (beats < TOTAL) && !stall;
    eclr  = ebv && (en == 0) && (ei == 0) && (ej == 0);
    elast = ebv && (en == NMAX) && (ei == K - 1) && (ej == K - 1);
    edone = active && (beats == TOTAL) && (off == done_off);
    ewr   = 1'b0;
    w     = '0;
    if (wr_q.size() > 0 && wr_q[0].off == off) begin
      ewr = 1'b1;
      w   = wr_q.pop_front();
    end
    check_val("iter", 48'({m, r, c, n, i, j}),
              48'({8'(em), 8'(er), 8'(ec), 8'(en), 4'(ei), 4'(ej)}));
    check_val("beat_valid", 48'(beat_valid), 48'(ebv));
    check_val("acc_clr", 48'(acc_clr), 48'(eclr));
    check_val("acc_last", 48'(acc_last), 48'(elast));
    check_val("busy", 48'(busy), 48'(active && !edone));
    check_val("done", 48'(done), 48'(edone));
    check_val("out_wr", 48'(out_wr), 48'(ewr));
    if (ewr) begin
      check_val("out_addr", 48'(out_addr), 48'(w.addr));
      check_val("out_chan", 48'(out_chan), 48'(w.chan));
    end
    if (beat_valid) n_bv++;
    if (acc_clr) n_clr++;
    if (acc_last) n_last++;
    if (out_wr) begin n_wr++; total_wr++; end
    if (ebv) begin
      if (elast) wr_q.push_back('{off + PD, 16'(er * OS + ec), 8'(em)});
      beats++;
      if (beats == TOTAL) begin last_off = off; done_off = off + PD + 1; end
      if (ej == K - 1) begin
        ej = 0;
        if (ei == K - 1) begin
          ei = 0;
          if (en == NMAX) begin
            en = 0;
            if (ec == OS - 1) begin
              ec = 0;
              if (er == OS - 1) begin er = 0; em = (em == OC - 1) ? 0 : em + 1; end
              else er++;
            end else ec++;
          end else en += NS;
        end else ei++;
      end else ej++;
    end
    if (edone) begin
      active = 1'b0; layers_done++; done_gap = off - last_off;
    end
    if (start && !active && rst_n) begin
      active = 1'b1; t0 = cyc; beats = 0; done_off = 0;
      n_bv = 0; n_clr = 0; n_last = 0; n_wr = 0;
    end
  end

  task automatic run_layer(input string tag, input int stall_at, input int stall_len, input int restart_at);
    int base;
    base  = layers_done;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k < 300 && layers_done == base; k++) begin
      stall = (k >= stall_at) && (k < stall_at + stall_len);
      start = (k == restart_at);
      @(posedge clock); #1;
    end
    stall = 1'b0; start = 1'b0;
    check_val({tag, "_layers"}, 48'(layers_done - base), 48'd1);
    check_val({tag, "_beats"}, 48'(n_bv), 48'(TOTAL));
    check_val({tag, "_clr_cnt"}, 48'(n_clr), 48'(TOTAL / (K * K)));
    check_val({tag, "_last_cnt"}, 48'(n_last), 48'(TOTAL / (K * K)));
    check_val({tag, "_wr_cnt"}, 48'(n_wr), 48'(OC * OS * OS));
    check_val({tag, "_done_gap"}, 48'(done_gap), 48'(PD + 1));
    check_val({tag, "_q_empty"}, 48'(wr_q.size()), 48'd0);
  endtask

  initial begin
    int wr_before, nbv, nwr, par;
    bit seen_done;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_ctl", 48'({busy, done, beat_valid, acc_clr, acc_last, out_wr, out_addr, out_chan}), 48'd0);
    check_val("rst_iter", 48'({m, r, c, n, i, j}), 48'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    run_layer("plain", 0, 0, 0);
    repeat (3) @(posedge clock); #1;
    run_layer("stall", 3, 3, 0);
    repeat (3) @(posedge clock); #1;
    run_layer("restart", 0, 0, 6);
    repeat (3) @(posedge clock); #1;

    // reset in the middle of a layer drops everything in flight
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_ctl", 48'({busy, done, beat_valid, acc_clr, acc_last, out_wr, out_addr, out_chan}), 48'd0);
    check_val("midrst_iter", 48'({m, r, c, n, i, j}), 48'd0);
    wr_before = total_wr;
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check_val("midrst_no_wr", 48'(total_wr - wr_before), 48'd0);

    // multi-step input channels: n alternates 0,4 per pixel
    start_b = 1'b1;
    @(posedge clock); #1;
    start_b = 1'b0;
    nbv = 0; nwr = 0; par = 0; seen_done = 1'b0;
    for (int k = 0; k < 40 && !seen_done; k++) begin
      @(negedge clock);
      if (beat_valid_b) begin
        check_val("b_n", 48'(n_b), (par != 0) ? 48'd4 : 48'd0);
        check_val("b_clr", 48'(acc_clr_b), (par != 0) ? 48'd0 : 48'd1);
        check_val("b_last", 48'(acc_last_b), (par != 0) ? 48'd1 : 48'd0);
        par = 1 - par;
        nbv++;
      end
      if (out_wr_b) nwr++;
      if (done_b) seen_done = 1'b1;
    end
    check_val("b_beats", 48'(nbv), 48'd8);
    check_val("b_wr_cnt", 48'(nwr), 48'd4);
    check_val("b_done_seen", 48'(seen_done), 48'd1);
    @(posedge clock); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_loop_sequencer.md
Name: conv_loop_sequencer

Overview:
- Generates the convolution loop iterators m, r, c, n, i, j that feed the address-generation controller.
- Produces per-beat framing strobes: accumulator clear on the first beat of an output pixel, and last-beat on the final beat.
- Drives a PIPE_DEPTH-delayed output-buffer write strobe, address and channel so that results land when the MAC datapath finishes.
- Sits between the top-level layer start/done handshake and the address controller / MAC array.

Parameters:
- K, 5, kernel size; i and j run 0..K-1
- OUT_SIZE, 28, output feature-map width and height; r and c run 0..OUT_SIZE-1
- OUT_CH, 6, output channels; m runs 0..OUT_CH-1
- IN_CH, 1, input channels; n runs 0, N_STEP, 2*N_STEP, ... while n < IN_CH
- N_STEP, 4, input channels packed per feature-map word
- PIPE_DEPTH, 9, cycles from beat issue to the MAC result being valid

Ports:
- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a layer; honoured only in IDLE
- stall  in  1  holds iterators while high in RUN
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at layer completion
- m  out  8  output-channel iterator
- r  out  8  output row iterator
- c  out  8  output column iterator
- n  out  8  input-channel iterator, steps by N_STEP
- i  out  4  kernel row iterator
- j  out  4  kernel column iterator
- beat_valid  out  1  iterators are a live beat this cycle
- acc_clr  out  1  live beat is the first of its output pixel (n=0, i=0, j=0)
- acc_last  out  1  live beat is the last of its output pixel
- out_wr  out  1  output-buffer write strobe, delayed
- out_addr  out  16  r*OUT_SIZE+c of the written pixel, delayed
- out_chan  out  8  m of the written pixel, delayed

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE; all iterators are 0.
  - busy, done, beat_valid, acc_clr, acc_last and out_wr are 0; out_addr and out_chan are 0.
  - Every delay-line stage is cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - Iterators are held at 0.
  - On start=1, go to RUN on the next edge.
- RUN:
  - beat_valid = ~stall.
  - On each non-stalled cycle, advance the odometer with j innermost, then i, n, c, r, m outermost.
  - A field that reaches its maximum wraps to 0 and carries to the next outer field. The maximum for n is the largest multiple of N_STEP below IN_CH.
  - When stall=1, every iterator holds, and beat_valid, acc_clr and acc_last are 0.
  - When the final beat issues without a stall, go to DRAIN with iterators at 0. The final beat has every field at its maximum.
  - The first beat is issued on the first RUN cycle.
- DRAIN:
  - Count PIPE_DEPTH cycles, with beat_valid=0.
  - Then go to DONE.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - busy=0 in DONE.
- start received outside IDLE is ignored.
- acc_clr and acc_last are combinational from the iterators and gated by beat_valid. Both are 1 together when K=1 and there is a single n step.
- Delay line:
  - PIPE_DEPTH stages carry {acc_last&beat_valid, r*OUT_SIZE+c, m}.
  - It shifts every cycle regardless of stall, so stall bubbles travel as zeros.
  - out_wr, out_addr and out_chan are the last stage's contents: out_wr equals that stage's acc_last&beat_valid bit, and the final write lands on the last DRAIN cycle.
- out_addr is computed at 16 bits without overflow, since OUT_SIZE^2 ≤ 65535.
- Total beats per layer = OUT_CH*OUT_SIZE^2*ceil(IN_CH/N_STEP)*K^2. Default: 117600.
- Latency from start to the first beat is 1 cycle. done follows the final beat by PIPE_DEPTH+1 cycles when there are no stalls.
- Reset asserted mid-layer returns to IDLE immediately and drops pending writes. Nothing resumes until a new start.

Test Plan:
- Smallest layer (K=2, OUT_SIZE=2, OUT_CH=2, IN_CH=1, PIPE_DEPTH=3), start pulse, no stall:
  - exactly 32 beat_valid cycles and 8 acc_clr and 8 acc_last;
  - out_wr at addresses 0,1,2,3 with chan 0, then 0,1,2,3 with chan 1;
  - done arrives 4 cycles after the last beat.
- Iterator order: capture {m,r,c,i,j} for the first 5 beats → (0,0,0,0,0), (0,0,0,0,1), (0,0,0,1,0), (0,0,0,1,1), (0,0,1,0,0).
- IN_CH=6, N_STEP=4, K=1: n sequence per pixel is 0,4; acc_clr on n=0 and acc_last on n=4.
- Stall asserted for 3 cycles mid-pixel: iterators freeze, beat_valid=0 throughout, and out_wr shifts later by exactly 3 cycles with the total write count unchanged.
- start pulsed again during RUN is ignored (beat count unchanged). Reset mid-layer: all outputs are 0 immediately, with no out_wr afterwards until a new start.
- Defaults: 117600 beats, 4704 out_wr pulses, done a single cycle, busy low after it.
